ifu_line_fetch: RTL and testbench

//  Front-end line fetcher sitting directly upstream of the instruction buffer.

---
 rtl/ifu_line_fetch.sv | 199 +++++++++++++++++++
 tb/tb_ifu_line_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_line_fetch.sv
// ifu_line_fetch
// Front-end line fetcher feeding the instruction buffer. Owns the fetch PC,
// issues one aligned line read at a time to the memory arbiter and hands each
// returned line to the buffer as a one-cycle pulse with held data. A backend
// redirect flushes the buffer and discards any line already in flight.

module ifu_line_fetch #(
    parameter int              PC_W       = 64,
    parameter int              LINE_BYTES = 64,
    parameter logic [PC_W-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_inst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [PC_W-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [511:0]    mem_resp_data,
    output logic            pc_index_ready,
    output logic [511:0]    pc_read_inst,
    output logic [PC_W-1:0] line_base_pc,
    output logic [3:0]      first_valid_idx,
    output logic            clear_ibuffer
);

    // Byte-offset mask inside one line and the stride between lines.
    localparam logic [PC_W-1:0] OFF_MASK   = PC_W'(LINE_BYTES - 1);
    localparam logic [PC_W-1:0] LINE_STEP  = PC_W'(LINE_BYTES);
    localparam logic [PC_W-1:0] RESET_ADDR = RESET_PC & ~OFF_MASK;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Clear the in-line byte offset to get the line address.
    function automatic logic [PC_W-1:0] align_line(input logic [PC_W-1:0] pc);
        return pc & ~OFF_MASK;
    endfunction

    // Instruction slot (32-bit granule) of a PC inside its line.
    function automatic logic [3:0] slot_idx(input logic [PC_W-1:0] pc);
        return 4'((pc & OFF_MASK) >> 2);
    endfunction

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pending_q, pending_d;
    logic            drop_q, drop_d;
    logic            redir_seen_q, redir_seen_d;
    logic            req_valid_q, req_valid_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic [511:0]    line_q, line_d;
    logic            ready_q, ready_d;
    logic [PC_W-1:0] base_q, base_d;
    logic [3:0]      idx_q, idx_d;
    logic            clear_q, clear_d;

    // Next-state and datapath decisions for the fetch controller.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        drop_d       = drop_q;
        redir_seen_d = redir_seen_q;
        req_addr_d   = req_addr_q;
        line_d       = line_q;
        ready_d      = 1'b0;
        base_d       = base_q;
        idx_d        = idx_q;
        clear_d      = redirect_valid;

        // A redirect always retargets the PC and queues a fresh request;
        // a refill pulse that arrives while busy is remembered one deep.
        if (redirect_valid) begin
            pc_d         = redirect_target;
            pending_d    = 1'b1;
            redir_seen_d = 1'b1;
        end else if (fetch_inst && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            S_IDLE: begin
                // Redirect wins over launching: the request must use the new PC,
                // which only becomes visible in pc_q next cycle.
                if (redirect_valid) begin
                    state_d = S_IDLE;
                end else if (pending_q || fetch_inst) begin
                    state_d    = S_REQ;
                    pending_d  = 1'b0;
                    req_addr_d = align_line(pc_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // The request is never withdrawn; a redirect only marks it stale.
                if (redirect_valid) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    // Deliver only a line that no redirect has overtaken.
                    if (!drop_q && !redirect_valid) begin
                        line_d       = mem_resp_data;
                        ready_d      = 1'b1;
                        base_d       = align_line(pc_q);
                        pc_d         = align_line(pc_q) + LINE_STEP;
                        idx_d        = redir_seen_q ? slot_idx(pc_q) : 4'd0;
                        redir_seen_d = 1'b0;
                    end else begin
                        line_d = line_q;
                    end
                end else if (redirect_valid) begin
                    state_d = S_WAIT;
                    drop_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_valid_d = (state_d == S_REQ);
    end

    // Controller state, fetch PC and bookkeeping flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pending_q    <= 1'b1;
            drop_q       <= 1'b0;
            redir_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            redir_seen_q <= redir_seen_d;
        end
    end

    // Registered memory request channel; address held for the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_ADDR;
        end else begin
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    // Registered line hand-off and flush pulse toward the instruction buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= 512'd0;
            ready_q <= 1'b0;
            base_q  <= {PC_W{1'b0}};
            idx_q   <= 4'd0;
            clear_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            ready_q <= ready_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            clear_q <= clear_d;
        end
    end

    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = req_addr_q;
    assign pc_index_ready  = ready_q;
    assign pc_read_inst    = line_q;
    assign line_base_pc    = base_q;
    assign first_valid_idx = idx_q;
    assign clear_ibuffer   = clear_q;

endmodule

// File: tb/tb_ifu_line_fetch.sv
// Bench for ifu_line_fetch: directed transactions; expected request addresses
// and returned lines are queued by the stimulus and checked by a monitor.

module tb_ifu_line_fetch;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fetch_inst = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_target = 64'd0;
    logic         mem_req_ready = 1'b0;
    logic         mem_resp_valid = 1'b0;
    logic [511:0] mem_resp_data = 512'd0;
    logic         mem_req_valid;
    logic [63:0]  mem_req_addr;
    logic         pc_index_ready;
    logic [511:0] pc_read_inst;
    logic [63:0]  line_base_pc;
    logic [3:0]   first_valid_idx;
    logic         clear_ibuffer;

    ifu_line_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_inst      (fetch_inst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .pc_index_ready  (pc_index_ready),
        .pc_read_inst    (pc_read_inst),
        .line_base_pc    (line_base_pc),
        .first_valid_idx (first_valid_idx),
        .clear_ibuffer   (clear_ibuffer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  base;
        logic [3:0]   idx;
    } line_t;

    line_t       exp_line_q[$];
    logic [63:0] exp_addr_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int accept_cnt = 0;
    int ready_cnt = 0;
    int clear_cnt = 0;

    localparam logic [511:0] D1 = {16{32'h1111_0001}};
    localparam logic [511:0] D2 = {16{32'h2222_0002}};
    localparam logic [511:0] D3 = {16{32'h3333_0003}};
    localparam logic [511:0] D4 = {16{32'h4444_0004}};
    localparam logic [511:0] D5 = {16{32'h5555_0005}};
    localparam logic [511:0] D6 = {16{32'h6666_0006}};
    localparam logic [511:0] D7 = {16{32'h7777_0007}};
    localparam logic [511:0] DS = {16{32'hDEAD_BEEF}};

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_line(input logic [511:0] d, input logic [63:0] b, input logic [3:0] i);
        line_t l;
        l.data = d;
        l.base = b;
        l.idx  = i;
        exp_line_q.push_back(l);
    endtask

    // Monitor: checks accepted requests and delivered lines against the queues.
    task automatic monitor();
        line_t       l;
        logic [63:0] a;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                accept_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_req", 512'(mem_req_addr), 512'(64'hFFFF_FFFF_FFFF_FFFF));
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("req_addr", 512'(mem_req_addr), 512'(a));
                end
            end
            if (pc_index_ready) begin
                ready_cnt++;
                if (exp_line_q.size() == 0) begin
                    chk("unexpected_line", 512'(line_base_pc), 512'(64'hFFFF_FFFF_FFFF_FFFF));
                end else begin
                    l = exp_line_q.pop_front();
                    chk("line_data", pc_read_inst, l.data);
                    chk("line_base", 512'(line_base_pc), 512'(l.base));
                    chk("line_idx", 512'(first_valid_idx), 512'(l.idx));
                end
            end
            if (clear_ibuffer) begin
                clear_cnt++;
                chk("clear_vs_ready", 512'(pc_index_ready), 512'(1'b0));
            end
        end
    endtask

    // One memory transaction: wait for the request, stall ready, respond.
    task automatic do_txn(input logic [63:0] exp_a, input int rdy_dly, input int rsp_dly,
                          input logic [511:0] data, input int n_fetch, input int redir_at,
                          input logic [63:0] tgt);
        int n;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 512'(mem_req_valid), 512'(1'b1));
        for (int i = 0; i < rdy_dly; i++) begin
            chk("req_hold_valid", 512'(mem_req_valid), 512'(1'b1));
            chk("req_hold_addr", 512'(mem_req_addr), 512'(exp_a));
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            fetch_inst      = ((i % 2) == 0) && ((i / 2) < n_fetch);
            redirect_valid  = (i == redir_at);
            redirect_target = tgt;
            step();
        end
        fetch_inst      = 1'b0;
        redirect_valid  = (redir_at == rsp_dly);
        redirect_target = tgt;
        mem_resp_valid  = 1'b1;
        mem_resp_data   = data;
        step();
        mem_resp_valid  = 1'b0;
        redirect_valid  = 1'b0;
    endtask

    initial begin
        int a0;
        int r0;
        int c0;
        fork
            monitor();
        join_none

        // Reset values
        step();
        step();
        chk("rst_req_valid", 512'(mem_req_valid), 512'(1'b0));
        chk("rst_req_addr", 512'(mem_req_addr), 512'(64'h8000_0000));
        chk("rst_ready", 512'(pc_index_ready), 512'(1'b0));
        chk("rst_data", pc_read_inst, 512'd0);
        chk("rst_base", 512'(line_base_pc), 512'(64'd0));
        chk("rst_idx", 512'(first_valid_idx), 512'(4'd0));
        chk("rst_clear", 512'(clear_ibuffer), 512'(1'b0));

        // 1: first fetch out of reset
        exp_addr_q.push_back(64'h8000_0000);
        exp_line(D1, 64'h8000_0000, 4'd0);
        rst_n = 1'b1;
        do_txn(64'h8000_0000, 0, 2, D1, 0, -1, 64'd0);
        chk("t1_ready_latency", 512'(pc_index_ready), 512'(1'b1));
        step();
        chk("t1_ready_pulse_end", 512'(pc_index_ready), 512'(1'b0));
        chk("t1_ready_cnt", 512'(ready_cnt), 512'(1));

        // 2: fetch latency and long ready stall
        exp_addr_q.push_back(64'h8000_0040);
        exp_line(D2, 64'h8000_0040, 4'd0);
        fetch_inst = 1'b1;
        step();
        fetch_inst = 1'b0;
        chk("t2_fetch_latency", 512'(mem_req_valid), 512'(1'b1));
        a0 = accept_cnt;
        do_txn(64'h8000_0040, 5, 1, D2, 0, -1, 64'd0);
        step();
        chk("t2_one_accept", 512'(accept_cnt - a0), 512'(1));

        // 3: two refill pulses during WAIT merge into one request
        exp_addr_q.push_back(64'h8000_0080);
        exp_line(D3, 64'h8000_0080, 4'd0);
        exp_addr_q.push_back(64'h8000_00C0);
        fetch_inst = 1'b1;
        step();
        fetch_inst = 1'b0;
        do_txn(64'h8000_0080, 0, 4, D3, 2, -1, 64'd0);
        chk("t3_idle_gap", 512'(mem_req_valid), 512'(1'b0));
        step();
        chk("t3_pending_req", 512'(mem_req_valid), 512'(1'b1));
        chk("t3_pending_addr", 512'(mem_req_addr), 512'(64'h8000_00C0));

        // 4: redirect during WAIT drops the stale line
        c0 = clear_cnt;
        r0 = ready_cnt;
        do_txn(64'h8000_00C0, 0, 3, DS, 0, 1, 64'h8000_1234);
        chk("t4_no_stale_pulse", 512'(pc_index_ready), 512'(1'b0));
        exp_addr_q.push_back(64'h8000_1200);
        exp_line(D4, 64'h8000_1200, 4'd13);
        do_txn(64'h8000_1200, 0, 1, D4, 0, -1, 64'd0);
        chk("t4_clear_cnt", 512'(clear_cnt - c0), 512'(1));
        step();
        step();
        step();
        chk("t4_line_cnt", 512'(ready_cnt - r0), 512'(1));
        chk("t3_no_extra_req", 512'(mem_req_valid), 512'(1'b0));

        // 5: redirect coincident with the response
        c0 = clear_cnt;
        exp_addr_q.push_back(64'h8000_1240);
        exp_addr_q.push_back(64'h0000_0000_0000_1000);
        exp_line(D5, 64'h0000_0000_0000_1000, 4'd2);
        fetch_inst = 1'b1;
        step();
        fetch_inst = 1'b0;
        do_txn(64'h8000_1240, 0, 2, DS, 0, 2, 64'h0000_0000_0000_1008);
        chk("t5_dropped", 512'(pc_index_ready), 512'(1'b0));
        do_txn(64'h0000_0000_0000_1000, 1, 1, D5, 0, -1, 64'd0);
        step();
        chk("t5_clear_cnt", 512'(clear_cnt - c0), 512'(1));

        // 6: redirect in IDLE to last line, wrap, then reset mid-WAIT
        redirect_valid  = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFC0;
        step();
        redirect_valid = 1'b0;
        chk("t6_clear_pulse", 512'(clear_ibuffer), 512'(1'b1));
        chk("t6_idle_hold", 512'(mem_req_valid), 512'(1'b0));
        exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFC0);
        exp_line(D6, 64'hFFFF_FFFF_FFFF_FFC0, 4'd0);
        do_txn(64'hFFFF_FFFF_FFFF_FFC0, 0, 1, D6, 0, -1, 64'd0);
        exp_addr_q.push_back(64'd0);
        fetch_inst = 1'b1;
        step();
        fetch_inst = 1'b0;
        chk("t6_wrap_valid", 512'(mem_req_valid), 512'(1'b1));
        chk("t6_wrap_addr", 512'(mem_req_addr), 512'(64'd0));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        rst_n          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DS;
        step();
        mem_resp_valid = 1'b0;
        chk("t6_rst_valid", 512'(mem_req_valid), 512'(1'b0));
        chk("t6_rst_addr", 512'(mem_req_addr), 512'(64'h8000_0000));
        chk("t6_rst_ready", 512'(pc_index_ready), 512'(1'b0));
        chk("t6_rst_data", pc_read_inst, 512'd0);
        chk("t6_rst_base", 512'(line_base_pc), 512'(64'd0));
        chk("t6_rst_idx", 512'(first_valid_idx), 512'(4'd0));
        chk("t6_rst_clear", 512'(clear_ibuffer), 512'(1'b0));
        exp_addr_q.push_back(64'h8000_0000);
        exp_line(D7, 64'h8000_0000, 4'd0);
        rst_n = 1'b1;
        do_txn(64'h8000_0000, 0, 1, D7, 0, -1, 64'd0);
        step();
        step();
        chk("addr_q_drained", 512'(exp_addr_q.size()), 512'(0));
        chk("line_q_drained", 512'(exp_line_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
